// File: rtl/pwm_generator_if.sv
// Duty-offer handshake between a duty source (master) and the PWM block (slave).
interface pwm_generator_if #(
  parameter int R = 4
);
  logic [R:0] duty;
  logic       duty_valid;
  logic       duty_ready;

  modport master (output duty, output duty_valid, input duty_ready);
  modport slave  (input duty, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_generator.sv
// PWM generator with a 2^R-tick period, double-buffered duty and a graceful
// stop that always completes the period in progress.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped, cnt held at 0, pwm_out low, duty offers go straight
//       | into duty_act
// RUN   | counting on tick, pwm_out = (cnt < duty_act)
// STOP  | stop requested, still counting; leaves for IDLE at the period
//       | boundary unless en returns first
module pwm_generator #(
  parameter int R = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           en,
  pwm_generator_if.slave duty_if,
  output logic           pwm_out,
  output logic           period_done,
  output logic           busy
);

  localparam logic [R-1:0] CNT_MAX  = '1;
  localparam logic [R:0]   DUTY_MAX = {1'b1, {R{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t       state, state_nxt;
  logic [R-1:0] cnt, cnt_nxt;
  logic [R:0]   duty_act, duty_act_nxt;
  logic [R:0]   duty_pend, duty_pend_nxt;
  logic         pend_valid, pend_valid_nxt;
  logic         pwm_nxt;
  logic         active, boundary, accept;
  logic [R:0]   duty_sat;

  assign duty_if.duty_ready = !pend_valid;
  assign period_done        = boundary;

  // Next-state, counter, duty buffering and waveform decode.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    duty_act_nxt   = duty_act;
    duty_pend_nxt  = duty_pend;
    pend_valid_nxt = pend_valid;

    active   = (state != IDLE);
    boundary = active && tick && (cnt == CNT_MAX);
    accept   = duty_if.duty_valid && !pend_valid;
    duty_sat = (duty_if.duty > DUTY_MAX) ? DUTY_MAX : duty_if.duty;

    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP: begin
        if (en)            state_nxt = RUN;
        else if (boundary) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == IDLE)    cnt_nxt = '0;
    else if (active && tick)  cnt_nxt = cnt + R'(1);

    if (!active) begin
      if (accept) duty_act_nxt = duty_sat;
    end else begin
      // duty_act only moves on a boundary, so a period never changes shape
      if (boundary && pend_valid) begin
        duty_act_nxt   = duty_pend;
        pend_valid_nxt = 1'b0;
      end
      if (accept) begin
        duty_pend_nxt  = duty_sat;
        pend_valid_nxt = 1'b1;
      end
    end

    // A value accepted on the very boundary that drops us into IDLE would
    // otherwise sit pending with duty_ready low forever; promote it instead.
    if (active && (state_nxt == IDLE) && pend_valid_nxt) begin
      duty_act_nxt   = duty_pend_nxt;
      pend_valid_nxt = 1'b0;
    end

    pwm_nxt = (state_nxt != IDLE) && ({1'b0, cnt_nxt} < duty_act_nxt);
  end

  // State, counter, duty and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      duty_act   <= '0;
      duty_pend  <= '0;
      pend_valid <= 1'b0;
      pwm_out    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      duty_act   <= duty_act_nxt;
      duty_pend  <= duty_pend_nxt;
      pend_valid <= pend_valid_nxt;
      pwm_out    <= pwm_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator at R=4 (16-tick period).
module tb_pwm_generator;

  localparam int R   = 4;
  localparam int PER = 1 << R;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic tick  = 1'b1;
  logic en    = 1'b0;
  logic pwm_out, period_done, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_div = 1;
  int tick_ph  = 0;

  pwm_generator_if #(.R(R)) duty_if ();

  pwm_generator #(.R(R)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .en          (en),
    .duty_if     (duty_if),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // tick changes just after the rising edge so it is stable at every sample
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_div <= 1) begin
        tick_ph = 0;
        tick    = 1'b1;
      end else begin
        tick_ph = (tick_ph + 1) % tick_div;
        tick    = (tick_ph == 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, 64'(got), 64'(exp));
  endtask

  task automatic capture(input int n, output logic [63:0] g_pw, output logic [63:0] g_pd,
                         output logic [63:0] g_rd, output logic [63:0] g_bz);
    g_pw = '0; g_pd = '0; g_rd = '0; g_bz = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g_pw[i] = pwm_out;
      g_pd[i] = period_done;
      g_rd[i] = duty_if.duty_ready;
      g_bz[i] = busy;
    end
  endtask

  // Runs n clocks with tick every clock; c0 is the cnt expected at the first
  // sample. d_old applies until the first boundary, d_new afterwards; ready
  // is rd0 until that boundary and 1 afterwards.
  task automatic run_check(input string tag, input int c0, input int n, input int d_old,
                           input int d_new, input logic rd0);
    logic [63:0] g_pw, g_pd, g_rd, g_bz;
    logic [63:0] e_pw, e_pd, e_rd, e_bz;
    int c, p, d;
    e_pw = '0; e_pd = '0; e_rd = '0; e_bz = '0;
    capture(n, g_pw, g_pd, g_rd, g_bz);
    for (int i = 0; i < n; i++) begin
      c = (c0 + i) % PER;
      p = (c0 + i) / PER;
      d = (p == 0) ? d_old : d_new;
      e_pw[i] = (c < d);
      e_pd[i] = (c == PER - 1);
      e_rd[i] = (p == 0) ? rd0 : 1'b1;
      e_bz[i] = 1'b1;
    end
    chk({tag, " pwm"},   g_pw, e_pw);
    chk({tag, " done"},  g_pd, e_pd);
    chk({tag, " ready"}, g_rd, e_rd);
    chk({tag, " busy"},  g_bz, e_bz);
  endtask

  task automatic offer(input string tag, input int d, input logic exp_rd);
    logic [31:0] dv;
    dv = d;
    duty_if.duty       = dv[R:0];
    duty_if.duty_valid = 1'b1;
    @(negedge clk);
    chk1({tag, " ready"}, duty_if.duty_ready, exp_rd);
    duty_if.duty_valid = 1'b0;
  endtask

  // Asserts reset between edges so the outputs must react asynchronously.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk1({tag, " pwm"},   pwm_out, 1'b0);
    chk1({tag, " done"},  period_done, 1'b0);
    chk1({tag, " busy"},  busy, 1'b0);
    chk1({tag, " ready"}, duty_if.duty_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] g_pw, g_pd, g_rd, g_bz;
    int pd_first, pd_second, pd_count, high_cnt;
    logic pw_hist [120];

    duty_if.duty       = '0;
    duty_if.duty_valid = 1'b0;
    #2;
    do_reset("rst0");

    // duty 4 taken directly in IDLE, then run
    offer("idle4", 4, 1'b1);
    chk1("idle pwm", pwm_out, 1'b0);
    chk1("idle busy", busy, 1'b0);
    en = 1'b1;
    run_check("d4", 0, 38, 4, 4, 1'b1);

    // offer 12 at cnt=5: current period keeps 4, next is 12
    offer("o12", 12, 1'b0);
    run_check("d12", 7, 25, 4, 12, 1'b0);

    // offer on the boundary clock: held pending for a full period
    offer("o0", 0, 1'b0);
    run_check("d0", 1, 31, 12, 0, 1'b0);
    offer("o16", 16, 1'b0);
    run_check("d16", 1, 31, 0, 16, 1'b0);
    offer("o31", 31, 1'b0);
    run_check("d31", 1, 31, 16, 16, 1'b0);
    offer("o4", 4, 1'b0);
    run_check("d4b", 1, 23, 16, 4, 1'b0);

    // en dropped at cnt=7: finish the period then IDLE
    en = 1'b0;
    capture(10, g_pw, g_pd, g_rd, g_bz);
    chk("stop pwm",   g_pw, 64'h000);
    chk("stop done",  g_pd, 64'h080);
    chk("stop ready", g_rd, 64'h3FF);
    chk("stop busy",  g_bz, 64'h0FF);

    // restart from 0, drop en at cnt=7, re-raise at cnt=10
    en = 1'b1;
    run_check("rs", 0, 8, 4, 4, 1'b1);
    en = 1'b0;
    run_check("stp", 8, 3, 4, 4, 1'b1);
    en = 1'b1;
    run_check("rer", 11, 21, 4, 4, 1'b1);

    // reset at cnt=9 with a pending duty
    offer("o14", 14, 1'b0);
    run_check("d14", 1, 24, 4, 14, 1'b0);
    offer("o2", 2, 1'b0);
    chk1("pre-rst pwm", pwm_out, 1'b1);
    en = 1'b0;
    do_reset("rst1");
    capture(4, g_pw, g_pd, g_rd, g_bz);
    chk("idle2 pwm",  g_pw, 64'h0);
    chk("idle2 busy", g_bz, 64'h0);
    en = 1'b1;
    run_check("post", 0, 20, 0, 0, 1'b1);

    // tick every third clock, duty 5
    en = 1'b0;
    do_reset("rst2");
    offer("idle5", 5, 1'b1);
    tick_div = 3;
    en = 1'b1;
    pd_first  = -1;
    pd_second = -1;
    pd_count  = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      pw_hist[i] = pwm_out;
      if (period_done) begin
        pd_count++;
        if (pd_first < 0)       pd_first = i;
        else if (pd_second < 0) pd_second = i;
      end
    end
    high_cnt = 0;
    if (pd_first >= 0 && pd_second > pd_first)
      for (int i = pd_first + 1; i <= pd_second; i++)
        if (pw_hist[i]) high_cnt++;
    chk("t3 period", 64'(pd_second - pd_first), 64'd48);
    chk("t3 pulses", 64'(pd_count), 64'd2);
    chk("t3 high",   64'(high_cnt), 64'd15);
    chk1("t3 busy", busy, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 Parameter R, default 4, sets counter resolution; the PWM period is 2^R ticks.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 tick  input  1  one-cycle count-advance strobe, driven by the upstream timer done output.
REQ-005 en  input  1  level; 1 requests PWM running, 0 requests a stop at the end of the current period.
REQ-006 duty  input  R+1  requested duty in ticks; legal values 0..2^R, larger values saturate to 2^R.
REQ-007 duty_valid  input  1  duty offer strobe.
REQ-008 duty_ready  output  1  block can accept a duty offer this cycle.
REQ-009 pwm_out  output  1  registered PWM waveform.
REQ-010 period_done  output  1  one-cycle pulse at each period boundary.
REQ-011 busy  output  1  high when the state machine is not in IDLE.

Function
REQ-012 The state machine SHALL have three states: IDLE, RUN and STOP, all registered.
REQ-013 IDLE SHALL go to RUN on the first clk with en=1; cnt SHALL then start from 0.
REQ-014 RUN SHALL go to STOP on a clk with en=0.
REQ-015 STOP SHALL go back to RUN on a clk with en=1, continuing the counter without a restart.
REQ-016 STOP SHALL go to IDLE at the period boundary.
REQ-017 Counter cnt (R bits) SHALL hold when tick=0 or in IDLE.
REQ-018 In RUN/STOP with tick=1, cnt SHALL increment and wrap from 2^R-1 to 0.
REQ-019 A period boundary is a clk with tick=1, cnt=2^R-1 and state RUN or STOP.
REQ-020 period_done SHALL be 1 for exactly that cycle.
REQ-021 On entering IDLE, cnt SHALL clear to 0.
REQ-022 Duty SHALL be held in two registers: duty_act (in use) and duty_pend (pending), plus a pend_valid flag.
REQ-023 duty_ready SHALL equal !pend_valid.
REQ-024 An offer is accepted on a clk with duty_valid && duty_ready.
REQ-025 An accepted value SHALL be saturated to 2^R before it is stored.
REQ-026 In IDLE, an accepted value SHALL be written directly to duty_act and pend_valid SHALL stay 0.
REQ-027 In RUN/STOP, an accepted value SHALL be written to duty_pend and pend_valid SHALL be set to 1.
REQ-028 At a period boundary with pend_valid=1, duty_act SHALL load duty_pend and pend_valid SHALL clear.
REQ-029 duty_act SHALL never change mid-period, so no glitch pulses appear on pwm_out.
REQ-030 An accept and a boundary in the same cycle with pend_valid=0 SHALL store to duty_pend, applied at the next boundary.
REQ-031 pwm_out SHALL be a flop whose value in RUN/STOP equals (cnt < duty_act) for the current cnt and duty_act register values.
REQ-032 The pwm_out flop SHALL be computed from next-state values, giving zero lag relative to cnt.
REQ-033 pwm_out SHALL be 0 in IDLE.
REQ-034 duty_act=0 SHALL give constant 0; duty_act=2^R SHALL give constant 1 over whole periods.
REQ-035 Offers with duty_ready=0 SHALL be ignored; the source holds duty_valid until it is accepted.
REQ-036 busy SHALL be registered and equal (state != IDLE).

Reset
REQ-037 rst_n=0 SHALL immediately force state=IDLE, cnt=0, duty_act=0, duty_pend=0, pend_valid=0.
REQ-038 rst_n=0 SHALL immediately force pwm_out=0, period_done=0, busy=0 and duty_ready=1.
REQ-039 A reset mid-period SHALL discard the pending duty; after release the block waits in IDLE for en.

Verification (R=4, tick=1 every cycle unless stated)
REQ-040 Duty 4 accepted in IDLE, then en=1 -> pwm_out high for 4 cycles and low for 12, repeating; period_done pulses every 16 cycles.
REQ-041 Running at duty 4, offer duty 12 at cnt=5 -> duty_ready drops; the current period stays at 4 high; the next period is 12 high; duty_ready rises at the boundary.
REQ-042 Duty offers 0, 16 and 31 -> constant 0, constant 1, and constant 1 (saturated to 16) respectively.
REQ-043 en dropped at cnt=7 -> block finishes to cnt=15, pulses period_done, enters IDLE with pwm_out=0; en re-raised at cnt=10 instead -> stays running with no counter restart.
REQ-044 tick every 3rd cycle -> cnt advances only on tick; period equals 48 clocks; pwm_out is high for 3*duty clocks.
REQ-045 rst_n asserted at cnt=9 with a pending duty -> all outputs reset asynchronously; after release pwm_out stays 0 until new en, and the pending value is never applied.
